exe_mem_pipe_reg: RTL
=====================

EXE_MEM_PIPE_REG -- requirements
Module: exe_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DSIZE, default 32, data/result/store-data width.
REQ-002 SHALL have parameter ASIZE, default 5, register-file write-address width.
REQ-003 SHALL have parameter ISIZE, default 32, PC width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  EXE stage presents a valid bundle.
REQ-008 SHALL have port in_ready  output  1  stage can accept a bundle this cycle.
REQ-009 SHALL have ports wen_in, mem_write_in, mem_read_in, mem_to_reg_in, jal_in  input  1 each  control fields of the bundle.
REQ-010 SHALL have ports rdata2_in, result_in  input  DSIZE each; waddr_in  input  ASIZE; PC_jal_in  input  ISIZE.
REQ-011 SHALL have ports with matching *_out names and widths  output  registered bundle toward MEM.
REQ-012 SHALL have port out_valid  output  1  *_out holds a valid bundle.
REQ-013 SHALL have port out_ready  input  1  MEM consumes the bundle this cycle.
REQ-014 SHALL have port flush  input  1  discard all held and incoming bundles.
REQ-015 SHALL have port stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-016 SHALL hold two entries: main (drives *_out) and skid; each with its own valid bit.
REQ-017 SHALL drive in_ready = NOT skid_valid, purely from registered state (no in_valid/out_ready path).
REQ-018 SHALL accept a bundle when in_valid AND in_ready AND NOT flush.
REQ-019 SHALL load an accepted bundle into main when main is empty or main is drained the same cycle and skid is empty; otherwise into skid.
REQ-020 SHALL, on drain (out_valid AND out_ready) with skid_valid=1, move skid into main and clear skid_valid in the same edge.
REQ-021 SHALL, on drain with skid empty and no accept, clear main_valid.
REQ-022 SHALL drive out_valid = main_valid; latency accept-to-out_valid is 1 cycle when empty.
REQ-023 SHALL preserve bundle order; no bundle duplicated or dropped except by flush.
REQ-024 SHALL keep *_out data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL force wen_out, mem_write_out, mem_read_out, jal_out to 0 whenever out_valid=0; data fields unconstrained then.
REQ-026 SHALL, on flush=1, clear main_valid and skid_valid at the next edge, discard any same-cycle input, and override all other updates.
REQ-027 SHALL increment stall_cnt each cycle with out_valid=1 AND out_ready=0 AND flush=0, saturating at 2^CNT_W-1.
REQ-028 SHALL support simultaneous accept and drain with skid empty at full throughput (one bundle per cycle).

Reset
REQ-029 SHALL, at an edge with rst_n=0, clear main_valid, skid_valid, stall_cnt and all *_out fields to 0, overriding flush and handshakes.
REQ-030 SHALL present out_valid=0, in_ready=1, stall_cnt=0 from the first edge with rst_n=0, including reset mid-transfer (held bundles lost).

Verification
REQ-031 SHALL verify streaming: out_ready=1, three bundles result_in=0x11,0x22,0x33 back-to-back -> result_out 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept.
REQ-032 SHALL verify skid: out_ready=0, bundles A=0xA, B=0xB accepted -> in_ready=0 after B; out_ready=1 -> A then B output, in_ready=1 again after A drains.
REQ-033 SHALL verify flush: both entries full, flush=1 with in_valid=1 (C=0xC) -> next cycle out_valid=0, in_ready=1, C never appears.
REQ-034 SHALL verify bubble gating: out_valid=0 with wen_in=mem_write_in=1 unaccepted -> wen_out=mem_write_out=mem_read_out=jal_out=0.
REQ-035 SHALL verify stall counter: CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3.
REQ-036 SHALL verify reset mid-operation: both entries full, stall_cnt=7, rst_n=0 one edge -> out_valid=0, in_ready=1, stall_cnt=0, all *_out=0.

Source files
------------

// File: rtl/exe_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_reg
//   EXE -> MEM pipeline register built as a two-entry skid buffer. The "main"
//   entry drives the *_out ports; the "skid" entry catches one bundle that
//   arrives while main is held by back-pressure, so that in_ready can be a
//   pure register output with no combinational path from out_ready.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : upstream handshake (EXE side)
//   *_in                : bundle fields from EXE
//   out_valid/out_ready : downstream handshake (MEM side)
//   *_out               : registered bundle toward MEM
//   flush               : drop held and incoming bundles at the next edge
//   stall_cnt           : saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module exe_mem_pipe_reg #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int ISIZE = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wen_in,
    input  logic             mem_write_in,
    input  logic             mem_read_in,
    input  logic             mem_to_reg_in,
    input  logic             jal_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] result_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ISIZE-1:0] PC_jal_in,
    output logic             wen_out,
    output logic             mem_write_out,
    output logic             mem_read_out,
    output logic             mem_to_reg_out,
    output logic             jal_out,
    output logic [DSIZE-1:0] rdata2_out,
    output logic [DSIZE-1:0] result_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic [ISIZE-1:0] PC_jal_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             wen;
        logic             mem_write;
        logic             mem_read;
        logic             mem_to_reg;
        logic             jal;
        logic [DSIZE-1:0] rdata2;
        logic [DSIZE-1:0] result;
        logic [ASIZE-1:0] waddr;
        logic [ISIZE-1:0] pc_jal;
    } bundle_t;

    bundle_t          in_bundle;
    bundle_t          main_reg, main_next;
    bundle_t          skid_reg, skid_next;
    logic             main_valid_reg, main_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             accept;
    logic             drain;

    assign in_bundle = '{wen:        wen_in,
                         mem_write:  mem_write_in,
                         mem_read:   mem_read_in,
                         mem_to_reg: mem_to_reg_in,
                         jal:        jal_in,
                         rdata2:     rdata2_in,
                         result:     result_in,
                         waddr:      waddr_in,
                         pc_jal:     PC_jal_in};

    // Skid is only ever occupied while main is, so a free skid slot means
    // there is always somewhere to put an incoming bundle.
    assign in_ready = ~skid_valid_reg;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_valid_reg & out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        stall_cnt_next  = stall_cnt_reg;

        if (flush) begin
            // Held data is left in place; only the valid bits matter.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (main_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_next = stall_cnt_reg + 1'b1;
            end

            if (drain && skid_valid_reg) begin
                // in_ready is low here, so no accept can collide with the move.
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                if (!main_valid_reg || drain) begin
                    main_next       = in_bundle;
                    main_valid_next = 1'b1;
                end else begin
                    skid_next       = in_bundle;
                    skid_valid_next = 1'b1;
                end
            end else if (drain) begin
                main_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    // Side-effecting controls are masked on bubbles so MEM/WB never act on
    // stale data sitting in an invalid main entry.
    assign out_valid      = main_valid_reg;
    assign wen_out        = main_reg.wen & main_valid_reg;
    assign mem_write_out  = main_reg.mem_write & main_valid_reg;
    assign mem_read_out   = main_reg.mem_read & main_valid_reg;
    assign jal_out        = main_reg.jal & main_valid_reg;
    assign mem_to_reg_out = main_reg.mem_to_reg;
    assign rdata2_out     = main_reg.rdata2;
    assign result_out     = main_reg.result;
    assign waddr_out      = main_reg.waddr;
    assign PC_jal_out     = main_reg.pc_jal;
    assign stall_cnt      = stall_cnt_reg;

endmodule
